// File: rtl/fifo_burst_rd_pkg.sv
// Shared types and default sizing for the FIFO-to-burst reader.
package fifo_burst_rd_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCmd  = 2'd1,
    StData = 2'd2
  } state_e;

  localparam int unsigned DEF_DATA_WIDTH = 16;
  localparam int unsigned DEF_BURST_LEN  = 128;
  localparam int unsigned DEF_ADDR_WIDTH = 28;

endpackage

// File: rtl/burst_skid_buf.sv
// Two-entry skid buffer; entry 0 is always the head presented downstream.
module burst_skid_buf #(
  parameter int unsigned DATA_WIDTH = fifo_burst_rd_pkg::DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data,
  output logic [1:0]            count
);

  logic [DATA_WIDTH-1:0] ent0_q, ent0_d, ent1_q, ent1_d;
  logic [1:0]            cnt_q, cnt_d, cnt_pop;

  always_comb begin
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    cnt_pop = cnt_q;
    if (pop && (cnt_q != 2'd0)) begin
      ent0_d  = ent1_q;
      cnt_pop = cnt_q - 2'd1;
    end
    cnt_d = cnt_pop;
    // A push lands in the first slot left free after this cycle's pop.
    if (push && (cnt_pop != 2'd2)) begin
      if (cnt_pop == 2'd0) begin
        ent0_d = push_data;
      end else begin
        ent1_d = push_data;
      end
      cnt_d = cnt_pop + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      cnt_q  <= cnt_d;
    end
  end

  assign valid = (cnt_q != 2'd0);
  assign data  = ent0_q;
  assign count = cnt_q;

endmodule

// File: rtl/fifo_burst_rd.sv
// Drains a FIFO into fixed-length write bursts over a cyclic frame buffer.
// Optional sticky underrun flag enabled by defining FIFO_BURST_RD_ERR_EN.
module fifo_burst_rd
  import fifo_burst_rd_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned BURST_LEN   = DEF_BURST_LEN,
  parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned FRAME_WORDS = 1024 * 768
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_empty,
  input  logic                  fifo_almost_empty,
  input  logic                  frame_sync,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [ADDR_WIDTH-1:0] cmd_addr,
  output logic                  wr_valid,
  input  logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_last,
  output logic                  busy
`ifdef FIFO_BURST_RD_ERR_EN
  ,
  output logic                  underrun_err
`endif
);

  localparam int unsigned CW = $clog2(BURST_LEN) + 1;
  localparam logic [CW-1:0] BL_CNT    = CW'(BURST_LEN);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH:0] END_ADDR =
      (ADDR_WIDTH + 1)'(BASE_ADDR) + (ADDR_WIDTH + 1)'(FRAME_WORDS);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, addr_next;
  logic [ADDR_WIDTH:0]   addr_inc;
  logic                  sync_q, sync_d;
  logic [CW-1:0]         req_q, req_d, beat_q, beat_d;
  logic                  rd_pend_q;
  logic                  rd_en;
  logic                  pop;
  logic                  buf_valid;
  logic [1:0]            buf_count;
  logic [1:0]            occ;

  burst_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rd_pend_q),
    .push_data (fifo_rd_data),
    .pop       (pop),
    .valid     (buf_valid),
    .data      (wr_data),
    .count     (buf_count)
  );

  assign pop       = buf_valid & wr_ready;
  // Words in flight plus words still buffered once this cycle's pop leaves.
  assign occ       = buf_count + {1'b0, rd_pend_q} - {1'b0, pop};
  assign addr_inc  = {1'b0, addr_q} + (ADDR_WIDTH + 1)'(BURST_LEN);
  assign addr_next = (addr_inc >= END_ADDR) ? BASE : addr_inc[ADDR_WIDTH-1:0];

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    sync_d  = sync_q | frame_sync;
    req_d   = req_q;
    beat_d  = beat_q;
    rd_en   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_almost_empty) begin
          state_d = StCmd;
          if (sync_q || frame_sync) addr_d = BASE;
          sync_d = 1'b0;
        end
      end
      StCmd: begin
        // First read issues on the handshake cycle so data reaches the head two cycles later.
        if (cmd_ready) begin
          state_d = StData;
          rd_en   = !fifo_empty;
        end
        if (rd_en) req_d = req_q + CW'(1);
      end
      StData: begin
        rd_en = !fifo_empty && (req_q < BL_CNT) && (occ < 2'd2);
        if (rd_en) req_d = req_q + CW'(1);
        if (pop) begin
          beat_d = beat_q + CW'(1);
          if (beat_q == LAST_BEAT) begin
            state_d = StIdle;
            addr_d  = addr_next;
            req_d   = '0;
            beat_d  = '0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      addr_q    <= BASE;
      sync_q    <= 1'b0;
      req_q     <= '0;
      beat_q    <= '0;
      rd_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      sync_q    <= sync_d;
      req_q     <= req_d;
      beat_q    <= beat_d;
      rd_pend_q <= rd_en;
    end
  end

  assign fifo_rd_en = rd_en;
  assign cmd_valid  = (state_q == StCmd);
  assign cmd_addr   = addr_q;
  assign wr_valid   = buf_valid;
  assign wr_last    = buf_valid && (state_q == StData) && (beat_q == LAST_BEAT);
  assign busy       = (state_q != StIdle);

`ifdef FIFO_BURST_RD_ERR_EN
  logic [7:0] starve_q;
  logic       err_q;

  // Flag fires on the 256th consecutive empty cycle inside a burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if ((state_q == StData) && fifo_empty) begin
        starve_q <= (starve_q == 8'hff) ? starve_q : starve_q + 8'd1;
      end else begin
        starve_q <= '0;
      end
      if (frame_sync) begin
        err_q <= 1'b0;
      end else if ((state_q == StData) && fifo_empty && (starve_q == 8'hff)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign underrun_err = err_q;
`else
  // No underrun monitor in this build.
`endif

endmodule

// File: tb/tb_fifo_burst_rd.sv
// Randomised scoreboard bench for fifo_burst_rd with a queue-based FIFO model.
module tb_fifo_burst_rd;

  localparam int unsigned DW   = 16;
  localparam int unsigned BL   = 128;
  localparam int unsigned AW   = 28;
  localparam int unsigned BASE = 0;
  localparam int unsigned FW   = 256;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          fifo_empty = 1'b1;
  logic          fifo_almost_empty = 1'b1;
  logic          frame_sync = 1'b0;
  logic          cmd_valid;
  logic          cmd_ready = 1'b1;
  logic [AW-1:0] cmd_addr;
  logic          wr_valid;
  logic          wr_ready = 1'b1;
  logic [DW-1:0] wr_data;
  logic          wr_last;
  logic          busy;
`ifdef FIFO_BURST_RD_ERR_EN
  logic          underrun_err;
`endif

  fifo_burst_rd #(
    .DATA_WIDTH  (DW),
    .BURST_LEN   (BL),
    .ADDR_WIDTH  (AW),
    .BASE_ADDR   (BASE),
    .FRAME_WORDS (FW)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .fifo_rd_en        (fifo_rd_en),
    .fifo_rd_data      (fifo_rd_data),
    .fifo_empty        (fifo_empty),
    .fifo_almost_empty (fifo_almost_empty),
    .frame_sync        (frame_sync),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_addr          (cmd_addr),
    .wr_valid          (wr_valid),
    .wr_ready          (wr_ready),
    .wr_data           (wr_data),
    .wr_last           (wr_last),
    .busy              (busy)
`ifdef FIFO_BURST_RD_ERR_EN
    ,
    .underrun_err      (underrun_err)
`endif
  );

  always #5 clk = ~clk;

  int unsigned   compared = 0;
  int unsigned   mismatched = 0;
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_data[$];
  logic [AW-1:0] exp_cmd[$];
  int unsigned   cyc = 0;
  int            gate_left = -1;  // words readable before the model FIFO starves; -1 = no limit
  bit            rand_ready = 1'b0;
  bit            rand_cmd = 1'b0;
  bit            chk_lat = 1'b0;
  int unsigned   ref_off = 0;     // reference frame offset of the next burst

  // Monitor state
  int unsigned   burst_beats = 0;
  int unsigned   bursts_done = 0;
  bit            hold_v = 1'b0;
  logic [DW-1:0] hold_d = '0;
  bit            cmd_hold_v = 1'b0;
  logic [AW-1:0] cmd_hold_a = '0;
  bit            lat_pending = 1'b0;
  int unsigned   cmd_cyc = 0;
  int unsigned   first_cyc = 0;

  task automatic check(input string name, input longint act, input longint exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // FIFO model: one-cycle read latency, flags updated at each edge.
  always @(posedge clk) begin
    logic [DW-1:0] w;
    cyc++;
    if (fifo_rd_en) begin
      check("rd_en_while_empty", fifo_empty, 0);
      if (!fifo_empty && fifo_q.size() > 0) begin
        w = fifo_q.pop_front();
        fifo_rd_data <= w;
        if (gate_left > 0) gate_left--;
      end
    end
    fifo_empty        <= (fifo_q.size() == 0) || (gate_left == 0);
    fifo_almost_empty <= (fifo_q.size() < BL) || (gate_left == 0);
  end

  always @(posedge clk) begin
    #1;
    wr_ready  = rand_ready ? 1'($urandom % 2) : 1'b1;
    cmd_ready = rand_cmd   ? 1'($urandom % 2) : 1'b1;
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!rst_n) begin
      burst_beats = 0;
      hold_v      = 1'b0;
      cmd_hold_v  = 1'b0;
      lat_pending = 1'b0;
    end else begin
      if (cmd_hold_v) begin
        check("cmd_valid_held", cmd_valid, 1);
        check("cmd_addr_stable", cmd_addr, cmd_hold_a);
      end
      if (cmd_valid) begin
        if (cmd_ready) begin
          check("cmd_expected", exp_cmd.size() > 0, 1);
          if (exp_cmd.size() > 0) check("cmd_addr", cmd_addr, exp_cmd.pop_front());
          cmd_hold_v  = 1'b0;
          cmd_cyc     = cyc;
          lat_pending = 1'b1;
        end else begin
          cmd_hold_v = 1'b1;
          cmd_hold_a = cmd_addr;
        end
      end
      if (hold_v) begin
        check("wr_valid_held", wr_valid, 1);
        check("wr_data_stable", wr_data, hold_d);
      end
      if (wr_valid) begin
        if (lat_pending) begin
          if (chk_lat) check("first_beat_latency", cyc - cmd_cyc, 2);
          lat_pending = 1'b0;
          first_cyc   = cyc;
        end
        if (wr_ready) begin
          check("beat_expected", exp_data.size() > 0, 1);
          if (exp_data.size() > 0) check("wr_data", wr_data, exp_data.pop_front());
          check("wr_last", wr_last, burst_beats == BL - 1);
          burst_beats++;
          if (burst_beats == BL) begin
            if (chk_lat) check("back_to_back_cycles", cyc - first_cyc, BL - 1);
            burst_beats = 0;
            bursts_done++;
          end
          hold_v = 1'b0;
        end else begin
          hold_v = 1'b1;
          hold_d = wr_data;
        end
      end else begin
        hold_v = 1'b0;
      end
    end
  end

  task automatic load_burst(input bit seq);
    logic [DW-1:0] w;
    exp_cmd.push_back(AW'(BASE + ref_off));
    ref_off = (ref_off + BL) % FW;
    for (int i = 0; i < BL; i++) begin
      w = seq ? DW'(i) : DW'($urandom);
      fifo_q.push_back(w);
      exp_data.push_back(w);
    end
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((exp_data.size() != 0 || busy) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    check(name, n < 3000, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_beats(input int unsigned target);
    int n = 0;
    while (burst_beats < target && n < 3000) begin
      @(posedge clk);
      n++;
    end
    check("wait_beats_timeout", n < 3000, 1);
    #1;
  endtask

  task automatic pulse_sync();
    frame_sync = 1'b1;
    @(posedge clk);
    #1;
    frame_sync = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_cmd_valid"}, cmd_valid, 0);
    check({tag, "_wr_valid"}, wr_valid, 0);
    check({tag, "_wr_last"}, wr_last, 0);
    check({tag, "_fifo_rd_en"}, fifo_rd_en, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Sequential data, full-rate handshakes, latency and back-to-back checks.
    chk_lat = 1'b1;
    load_burst(1'b1);
    wait_done("burst1_done");
    chk_lat = 1'b0;

    // Random wr_ready back-pressure.
    rand_ready = 1'b1;
    load_burst(1'b0);
    wait_done("burst2_done");
    rand_ready = 1'b0;

    // FIFO starves after 60 words for 20 cycles.
    gate_left = 60;
    load_burst(1'b1);
    n = 0;
    while (gate_left != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    check("starve_reached", n < 3000, 1);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("stall_beats", burst_beats, 60);
    @(posedge clk);
    #1;
    gate_left = -1;
    wait_done("burst3_done");

    // frame_sync mid-burst: current burst completes, next restarts at base.
    load_burst(1'b0);
    wait_beats(40);
    pulse_sync();
    ref_off = 0;
    wait_done("burst4_done");
    check("bursts_done", bursts_done, 4);

    rand_ready = 1'b1;
    rand_cmd   = 1'b1;
    load_burst(1'b0);
    wait_done("burst5_done");
    rand_ready = 1'b0;
    rand_cmd   = 1'b0;

    // Reset on beat 50 abandons the burst.
    load_burst(1'b0);
    wait_beats(50);
    rst_n = 1'b0;
    fifo_q.delete();
    exp_data.delete();
    exp_cmd.delete();
    ref_off = 0;
    repeat (2) @(negedge clk);
    check_quiet("midreset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    load_burst(1'b0);
    wait_done("burst7_done");

    // frame_sync while idle is applied at the next burst start.
    pulse_sync();
    ref_off = 0;
    repeat (3) @(posedge clk);
    #1;
    load_burst(1'b0);
    wait_done("burst8_done");

    rand_ready = 1'b1;
    rand_cmd   = 1'b1;
    for (int b = 0; b < 2; b++) begin
      load_burst(1'b0);
      wait_done("burst_rand_done");
    end

    check("exp_data_drained", exp_data.size(), 0);
    check("exp_cmd_drained", exp_cmd.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
